// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller for the execute stage.
//
// A start op (mult/multu/div/divu) latches the E-stage operands and counts down a
// fixed latency. HI/LO are written on the last busy edge. mthi/mtlo write HI/LO
// directly at the next edge while idle.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset, clears all state
//   E_MDop    in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   E_A       in   [31:0] rs operand
//   E_B       in   [31:0] rt operand
//   E_MDread  in   [1:0] 0 none, 1 mfhi, 2 mflo, 3 none
//   D_UseMD   in   D-stage instruction touches the MDU or HI/LO
//   MDResult  out  [31:0] HI or LO selected by E_MDread, else 0
//   HI, LO    out  [31:0] result registers
//   Busy      out  operation in flight
//   MDStall   out  stall request to the hazard unit
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MDop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [1:0]  E_MDread,
  input  logic        D_UseMD,
  output logic [31:0] MDResult,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        MDStall
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic start;
  assign start = (E_MDop >= OpMult) && (E_MDop <= OpDivu);

  // Arithmetic on the latched operands only.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] sq_mag, sr_mag, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

    a_neg = a_q[31];
    b_neg = b_q[31];
    // Divide on magnitudes so 0x80000000 / -1 needs no special case.
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    div_zero   = (b_q == 32'd0);
    // Divisor forced to 1 on zero keeps the dividers defined; result is discarded.
    b_mag_safe = div_zero ? 32'd1 : b_mag;
    b_safe     = div_zero ? 32'd1 : b_q;

    sq_mag = a_mag / b_mag_safe;
    sr_mag = a_mag % b_mag_safe;
    q_s    = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
    r_s    = a_neg ? (~sr_mag + 32'd1) : sr_mag;
    q_u    = a_q / b_safe;
    r_u    = a_q % b_safe;

    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    case (op_q)
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OpDiv: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      OpDivu: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          op_d    = E_MDop;
          a_d     = E_A;
          b_d     = E_B;
          cnt_d   = (E_MDop <= OpMultu) ? MultLoad : DivLoad;
        end else if (E_MDop == OpMthi) begin
          hi_d = E_A;
        end else if (E_MDop == OpMtlo) begin
          lo_d = E_A;
        end
      end
      StRun: begin
        // Any op arriving while running is ignored.
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          if (!(div_zero && (op_q == OpDiv || op_q == OpDivu))) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q == StRun);
  // Includes the issue cycle so a following HI/LO user cannot slip past the start.
  assign MDStall = D_UseMD && (Busy || start);

  always_comb begin
    case (E_MDread)
      2'd1:    MDResult = hi_q;
      2'd2:    MDResult = lo_q;
      default: MDResult = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed ops with hand-computed results. Each start op pushes
// its expected HI/LO and busy length; a monitor pops on every Busy falling edge.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_MDop;
  logic [31:0] E_A, E_B;
  logic [1:0]  E_MDread;
  logic        D_UseMD;
  logic [31:0] MDResult, HI, LO;
  logic        Busy, MDStall;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDop   (E_MDop),
    .E_A      (E_A),
    .E_B      (E_B),
    .E_MDread (E_MDread),
    .D_UseMD  (D_UseMD),
    .MDResult (MDResult),
    .HI       (HI),
    .LO       (LO),
    .Busy     (Busy),
    .MDStall  (MDStall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  // Issue one op for a single cycle, then return to none.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    E_MDop = op;
    E_A    = a;
    E_B    = b;
    tick();
    E_MDop = 3'd0;
  endtask

  // Bounded wait for Busy to drop, checking MDStall every busy cycle.
  task automatic wait_idle(input logic exp_stall);
    int n = 0;
    while (Busy && n < 64) begin
      check("stall_busy", {31'd0, MDStall}, {31'd0, exp_stall});
      tick();
      n++;
    end
    if (Busy) check("idle_timeout", {31'd0, Busy}, 32'd0);
  endtask

  // Monitor: a completion is the first non-busy sample after busy samples.
  initial begin : monitor
    logic busy_prev = 1'b0;
    int   busy_len  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) begin
        busy_len++;
      end else begin
        if (busy_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion: got HI=0x%08h LO=0x%08h expected none",
                     HI, LO);
          end else begin
            e = exp_q.pop_front();
            check("done_hi", HI, e.hi);
            check("done_lo", LO, e.lo);
            check("busy_len", busy_len, e.cycles);
          end
        end
        busy_len = 0;
      end
      busy_prev = (Busy === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset    = 1'b1;
    E_MDop   = 3'd0;
    E_A      = 32'd0;
    E_B      = 32'd0;
    E_MDread = 2'd0;
    D_UseMD  = 1'b1;
    tick();
    check("reset_stall", {31'd0, MDStall}, 32'd0);
    tick();
    reset = 1'b0;
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);

    // mult -2 * 3, stall during issue and run, released after.
    E_MDop = 3'd1; E_A = 32'hFFFF_FFFE; E_B = 32'd3;
    #1;
    check("stall_issue", {31'd0, MDStall}, 32'd1);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    tick();
    E_MDop = 3'd0;
    E_A = 32'h1234_5678; E_B = 32'h0BAD_F00D;  // must not affect the result
    wait_idle(1'b1);
    check("stall_after", {31'd0, MDStall}, 32'd0);
    E_MDread = 2'd2; #1;
    check("mflo", MDResult, 32'hFFFF_FFFA);
    E_MDread = 2'd0;

    // multu, no D-stage user: stall stays low.
    D_UseMD = 1'b0;
    E_MDop = 3'd1 + 3'd1; E_A = 32'hFFFF_FFFE; E_B = 32'd3;
    #1;
    check("nostall_issue", {31'd0, MDStall}, 32'd0);
    push(32'h0000_0002, 32'hFFFF_FFFA, 5);
    tick();
    E_MDop = 3'd0;
    wait_idle(1'b0);

    // div -7 / 2; reads during the run return the old HI/LO.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    E_MDread = 2'd1; #1;
    check("mfhi_busy", MDResult, 32'h0000_0002);
    E_MDread = 2'd2; #1;
    check("mflo_busy", MDResult, 32'hFFFF_FFFA);
    E_MDread = 2'd3; #1;
    check("mdread_none", MDResult, 32'd0);
    E_MDread = 2'd0;
    wait_idle(1'b0);

    // divu 7 / 2
    push(32'd1, 32'd3, 10);
    issue(3'd4, 32'd7, 32'd2);
    wait_idle(1'b0);

    // mthi / mtlo
    issue(3'd5, 32'h11, 32'd0);
    check("mthi_hi", HI, 32'h11);
    check("mthi_lo", LO, 32'd3);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    check("mtlo_lo", LO, 32'h22);
    check("mtlo_hi", HI, 32'h11);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);

    // div by zero leaves HI/LO untouched after the full latency.
    push(32'h11, 32'h22, 10);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(1'b0);

    // Overflow case 0x80000000 / -1.
    push(32'd0, 32'h8000_0000, 10);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(1'b0);

    // mult 3 * 7 with a second mult and an mthi arriving while busy.
    push(32'd0, 32'h15, 5);
    issue(3'd1, 32'd3, 32'd7);
    issue(3'd1, 32'd5, 32'd5);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    check("ignored_hi", HI, 32'd0);
    wait_idle(1'b0);

    // Reset in the third busy cycle aborts the op.
    push(32'd0, 32'd0, 3);
    issue(3'd1, 32'd9, 32'd9);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);

    push(32'd0, 32'h10, 5);
    issue(3'd1, 32'd4, 32'd4);
    wait_idle(1'b0);

    tick();
    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
